// File: rtl/privmode_seq.sv
// Privilege-mode and trap/return sequencer with a WFI wait/timeout state machine.
// It qualifies the raw trap, mret, sret and wfi requests from the M stage into commit strobes.
module privmode_seq #(
  parameter int S_SUPPORTED = 1,
  parameter int U_SUPPORTED = 1,
  parameter int WFI_TO_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallW,
  input  logic       TrapReqM,
  input  logic       TrapDelegM,
  input  logic       mretReqM,
  input  logic       sretReqM,
  input  logic       wfiReqM,
  input  logic       IntPendingM,
  input  logic [1:0] STATUS_MPP,
  input  logic       STATUS_SPP,
  input  logic       STATUS_TW,
  input  logic       STATUS_TSR,
  output logic       TrapM,
  output logic       NextPrivModeIsM,
  output logic       mretM,
  output logic       sretM,
  output logic       IllegalInstrM,
  output logic       WFIStallM,
  output logic [1:0] PrivilegeModeW
);

  localparam logic [1:0] MODE_M = 2'b11;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_U = 2'b00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_TOUT = 2'd2;

  localparam logic S_SUP = (S_SUPPORTED != 0);
  localparam logic U_SUP = (U_SUPPORTED != 0);

  localparam logic [WFI_TO_BITS-1:0] CNT_MAX = '1;
  localparam logic [WFI_TO_BITS-1:0] CNT_PRE = CNT_MAX - {{(WFI_TO_BITS-1){1'b0}}, 1'b1};
  localparam logic [WFI_TO_BITS-1:0] CNT_ONE = {{(WFI_TO_BITS-1){1'b0}}, 1'b1};

  logic [1:0]             r_priv;
  logic [1:0]             r_state;
  logic [WFI_TO_BITS-1:0] r_cnt;

  logic [1:0]             w_priv_nxt;
  logic [1:0]             w_state_nxt;
  logic [WFI_TO_BITS-1:0] w_cnt_nxt;

  logic w_idle;
  logic w_tout_fire;
  logic w_mret_act;
  logic w_sret_act;
  logic w_wfi_act;
  logic w_mret_ill;
  logic w_sret_ill;
  logic w_cnt_en;

  // An mret may only return to a mode that exists; MPP=10 is reserved and maps to M.
  function automatic logic [1:0] f_mret_mode(input logic [1:0] mpp);
    logic [1:0] m;
    case (mpp)
      MODE_S:  m = S_SUP ? MODE_S : MODE_M;
      MODE_U:  m = U_SUP ? MODE_U : MODE_M;
      default: m = MODE_M;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] f_sret_mode(input logic spp);
    logic [1:0] m;
    if (spp)
      m = MODE_S;
    else
      m = U_SUP ? MODE_U : MODE_S;
    return m;
  endfunction

  assign w_idle      = (r_state == ST_IDLE);
  assign w_tout_fire = (r_state == ST_TOUT) & ~TrapReqM;

  assign w_mret_act = w_idle & ~TrapReqM & mretReqM;
  assign w_sret_act = w_idle & ~TrapReqM & ~mretReqM & sretReqM;
  assign w_wfi_act  = w_idle & ~TrapReqM & ~mretReqM & ~sretReqM & wfiReqM;

  assign w_mret_ill = (r_priv != MODE_M);
  assign w_sret_ill = (r_priv == MODE_U) | ((r_priv == MODE_S) & STATUS_TSR) | ~S_SUP;

  assign w_cnt_en = STATUS_TW & (r_priv != MODE_M);

  assign IllegalInstrM = w_tout_fire | (w_mret_act & w_mret_ill) | (w_sret_act & w_sret_ill);
  assign TrapM         = TrapReqM | IllegalInstrM;
  assign mretM         = w_mret_act & ~w_mret_ill;
  assign sretM         = w_sret_act & ~w_sret_ill;

  // A WFI timeout always traps to M, regardless of delegation.
  assign NextPrivModeIsM = w_tout_fire | ~(S_SUP & TrapDelegM & (r_priv != MODE_M));

  assign WFIStallM      = (r_state == ST_WAIT) & ~(IntPendingM | TrapReqM);
  assign PrivilegeModeW = r_priv;

  always_comb begin
    w_priv_nxt = r_priv;
    if (TrapM)
      w_priv_nxt = NextPrivModeIsM ? MODE_M : MODE_S;
    else if (mretM)
      w_priv_nxt = f_mret_mode(STATUS_MPP);
    else if (sretM)
      w_priv_nxt = f_sret_mode(STATUS_SPP);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_wfi_act & ~IntPendingM)
          w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (IntPendingM | TrapReqM) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_en && (r_cnt != CNT_MAX)) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_PRE)
            w_state_nxt = ST_TOUT;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ST_TOUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_priv  <= MODE_M;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (~StallW) begin
      r_priv  <= w_priv_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_privmode_seq.sv
// Directed bench for privmode_seq: a vector table for single-cycle trap/xret decisions
// plus hand-written sequences for WFI waiting, timeout, stall freeze and reset.
module tb_privmode_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       StallW, TrapReqM, TrapDelegM, mretReqM, sretReqM, wfiReqM, IntPendingM;
  logic [1:0] STATUS_MPP;
  logic       STATUS_SPP, STATUS_TW, STATUS_TSR;
  logic       TrapM, NextPrivModeIsM, mretM, sretM, IllegalInstrM, WFIStallM;
  logic [1:0] PrivilegeModeW;

  int checks = 0;
  int errors = 0;

  privmode_seq #(.S_SUPPORTED(1), .U_SUPPORTED(1), .WFI_TO_BITS(8)) dut (
    .clk(clk), .reset(reset), .StallW(StallW), .TrapReqM(TrapReqM), .TrapDelegM(TrapDelegM),
    .mretReqM(mretReqM), .sretReqM(sretReqM), .wfiReqM(wfiReqM), .IntPendingM(IntPendingM),
    .STATUS_MPP(STATUS_MPP), .STATUS_SPP(STATUS_SPP), .STATUS_TW(STATUS_TW),
    .STATUS_TSR(STATUS_TSR), .TrapM(TrapM), .NextPrivModeIsM(NextPrivModeIsM), .mretM(mretM),
    .sretM(sretM), .IllegalInstrM(IllegalInstrM), .WFIStallM(WFIStallM),
    .PrivilegeModeW(PrivilegeModeW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       trap, deleg, mret, sret, wfi, intp;
    logic [1:0] mpp;
    logic       spp, tsr;
    logic       e_trap, e_nxm, e_mret, e_sret, e_ill, e_stall;
    logic [1:0] e_mode;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    StallW = 0; TrapReqM = 0; TrapDelegM = 0; mretReqM = 0; sretReqM = 0; wfiReqM = 0;
    IntPendingM = 0; STATUS_MPP = 2'b00; STATUS_SPP = 0; STATUS_TW = 0; STATUS_TSR = 0;
  endtask

  // Reset to M, then use a legal mret to drop to the requested mode.
  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    clear_inputs();
    reset = 1;
    #1 reset = 0;
    if (m != 2'b11) begin
      STATUS_MPP = m;
      mretReqM = 1;
      @(negedge clk);
      mretReqM = 0;
      STATUS_MPP = 2'b00;
    end
  endtask

  task automatic wait_stall_count(output int n);
    n = 0;
    while (WFIStallM === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    vec_t v;

    //          mode  tr dl mr sr wf ip mpp   sp ts | tr nm mr sr il st emode
    vecs[0]  = '{2'b00, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01};
    vecs[1]  = '{2'b11, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b11};
    vecs[2]  = '{2'b01, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b11};
    vecs[3]  = '{2'b11, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b10, 1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b11};
    vecs[4]  = '{2'b11, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00};
    vecs[5]  = '{2'b11, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01};
    vecs[6]  = '{2'b01, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 2'b11};
    vecs[7]  = '{2'b01, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 2'b11};
    vecs[8]  = '{2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 2'b11};
    vecs[9]  = '{2'b01, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00};
    vecs[10] = '{2'b11, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01};
    vecs[11] = '{2'b11, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b11};
    vecs[12] = '{2'b00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b01};
    vecs[13] = '{2'b01, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 2'b00, 1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01};
    vecs[14] = '{2'b11, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 2'b11, 1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b11};

    clear_inputs();
    reset = 1;
    #12;
    chk("reset priv", PrivilegeModeW, 2'b11);
    chk("reset TrapM", TrapM, 0);
    chk("reset mretM", mretM, 0);
    chk("reset sretM", sretM, 0);
    chk("reset WFIStallM", WFIStallM, 0);
    reset = 0;

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      set_mode(v.mode);
      chk($sformatf("vec%0d setup priv", i), PrivilegeModeW, v.mode);
      TrapReqM = v.trap; TrapDelegM = v.deleg; mretReqM = v.mret; sretReqM = v.sret;
      wfiReqM = v.wfi; IntPendingM = v.intp; STATUS_MPP = v.mpp; STATUS_SPP = v.spp;
      STATUS_TSR = v.tsr;
      #1;
      chk($sformatf("vec%0d TrapM", i), TrapM, v.e_trap);
      chk($sformatf("vec%0d NextPrivModeIsM", i), NextPrivModeIsM, v.e_nxm);
      chk($sformatf("vec%0d mretM", i), mretM, v.e_mret);
      chk($sformatf("vec%0d sretM", i), sretM, v.e_sret);
      chk($sformatf("vec%0d IllegalInstrM", i), IllegalInstrM, v.e_ill);
      chk($sformatf("vec%0d WFIStallM", i), WFIStallM, v.e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d next priv", i), PrivilegeModeW, v.e_mode);
      clear_inputs();
    end

    // WFI in U with TW=1 times out after 255 waiting cycles.
    set_mode(2'b00);
    STATUS_TW = 1; wfiReqM = 1;
    #1 chk("wfiU issue stall", WFIStallM, 0);
    @(negedge clk);
    wfiReqM = 0;
    #1;
    wait_stall_count(n);
    chk("wfiU stall cycles", n, 255);
    chk("wfiU tout TrapM", TrapM, 1);
    chk("wfiU tout Illegal", IllegalInstrM, 1);
    chk("wfiU tout NextM", NextPrivModeIsM, 1);
    @(negedge clk);
    #1;
    chk("wfiU after priv", PrivilegeModeW, 2'b11);
    chk("wfiU after TrapM", TrapM, 0);
    clear_inputs();

    // WFI in M with TW=1 never times out; xret in WAIT is ignored; interrupt wakes.
    set_mode(2'b11);
    STATUS_TW = 1; wfiReqM = 1;
    @(negedge clk);
    wfiReqM = 0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (WFIStallM !== 1'b1 || TrapM !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("wfiM 1000 cycles no timeout", bad, 0);
    mretReqM = 1; STATUS_MPP = 2'b00;
    #1;
    chk("wfiM mret ignored mretM", mretM, 0);
    chk("wfiM mret ignored TrapM", TrapM, 0);
    @(negedge clk);
    mretReqM = 0;
    #1;
    chk("wfiM priv kept", PrivilegeModeW, 2'b11);
    chk("wfiM still waiting", WFIStallM, 1);
    IntPendingM = 1;
    #1 chk("wake same-cycle stall", WFIStallM, 0);
    @(negedge clk);
    IntPendingM = 0;
    #1 chk("wake back in idle", WFIStallM, 0);
    clear_inputs();

    // StallW freezes the counter; a trap in the timeout cycle suppresses the timeout.
    set_mode(2'b00);
    STATUS_TW = 1; wfiReqM = 1;
    @(negedge clk);
    wfiReqM = 0;
    repeat (100) @(negedge clk);
    StallW = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("freeze stall held", WFIStallM, 1);
    chk("freeze priv held", PrivilegeModeW, 2'b00);
    StallW = 0;
    wait_stall_count(n);
    chk("freeze remaining cycles", n, 155);
    TrapReqM = 1; TrapDelegM = 1;
    #1;
    chk("tout+trap TrapM", TrapM, 1);
    chk("tout+trap Illegal", IllegalInstrM, 0);
    chk("tout+trap NextM", NextPrivModeIsM, 0);
    @(negedge clk);
    TrapReqM = 0; TrapDelegM = 0;
    #1;
    chk("tout+trap priv", PrivilegeModeW, 2'b01);
    chk("tout+trap idle", WFIStallM, 0);
    clear_inputs();

    // Asynchronous reset in WAIT takes effect without a clock edge.
    set_mode(2'b00);
    STATUS_TW = 1; wfiReqM = 1;
    @(negedge clk);
    wfiReqM = 0;
    repeat (10) @(negedge clk);
    #1 chk("rst pre stall", WFIStallM, 1);
    #1 reset = 1;
    #1;
    chk("rst async stall", WFIStallM, 0);
    chk("rst async priv", PrivilegeModeW, 2'b11);
    chk("rst async TrapM", TrapM, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    #1 chk("rst after idle", WFIStallM, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
